// File: rtl/bfm_apbslave.sv
// APB completer model: word memory, programmable wait states, error responses, transfer counters and master-protocol checking.
// Latency: WAITSTATES=N completes N+1 cycles after setup; PREADY holds low while waiting.
module bfm_apbslave #(
    parameter int AWIDTH = 10,
    parameter int TPD    = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [3:0]  WAITSTATES,
    input  logic        ERR_INJECT,
    output logic [15:0] WR_COUNT,
    output logic [15:0] RD_COUNT,
    output logic        PROTOCOL_ERR
);

    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    // TPD only shapes output timing in simulation wrappers; the RTL outputs are zero-delay.
    if (TPD < 0) begin : g_tpd_range
    end

    logic [31:0] mem_q [DEPTH] = '{default: '0};

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rd_q, rd_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic        perr_q, perr_d;
    logic        mem_we;
    logic        violation;

    assign violation = !PSEL || !PENABLE || (PADDR != addr_q) || (PWRITE != write_q)
                       || (write_q && (PWDATA != wdata_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rd_d      = rd_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        perr_d    = perr_q;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = WAITSTATES;
                    err_d   = ERR_INJECT || (PADDR[1:0] != 2'b00);
                    rd_d    = (!PWRITE && !err_d) ? mem_q[PADDR[AWIDTH+1:2]] : '0;
                    state_d = ST_ACCESS;
                    // Outputs are registered, so the first access cycle's response is decided here.
                    pready_d  = (WAITSTATES == 4'd0);
                    pslverr_d = pready_d && err_d;
                    prdata_d  = (pready_d && !PWRITE && !err_d) ? rd_d : '0;
                end else if (PSEL && PENABLE) begin
                    perr_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (violation) begin
                    perr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (pready_q) begin
                    if (!err_q) begin
                        if (write_q) begin
                            mem_we   = 1'b1;
                            wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
                        end else begin
                            rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
                        end
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    pready_d  = (cnt_q == 4'd1);
                    pslverr_d = pready_d && err_q;
                    prdata_d  = (pready_d && !write_q && !err_q) ? rd_q : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rd_q      <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            perr_q    <= perr_d;
        end
    end

    // Memory survives reset; a reset edge only suppresses an in-flight write.
    always_ff @(posedge PCLK) begin
        if (!PRESET && mem_we) begin
            mem_q[addr_q[AWIDTH+1:2]] <= wdata_q;
        end
    end

    assign PRDATA       = prdata_q;
    assign PREADY       = pready_q;
    assign PSLVERR      = pslverr_q;
    assign WR_COUNT     = wr_cnt_q;
    assign RD_COUNT     = rd_cnt_q;
    assign PROTOCOL_ERR = perr_q;

endmodule

// File: tb/tb_bfm_apbslave.sv
// Directed and randomized APB transfers against a word-array reference model of the completer.
module tb_bfm_apbslave;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  WAITSTATES;
    logic        ERR_INJECT;
    logic [15:0] WR_COUNT;
    logic [15:0] RD_COUNT;
    logic        PROTOCOL_ERR;

    bfm_apbslave #(.AWIDTH(10), .TPD(1)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .WAITSTATES(WAITSTATES), .ERR_INJECT(ERR_INJECT), .WR_COUNT(WR_COUNT),
        .RD_COUNT(RD_COUNT), .PROTOCOL_ERR(PROTOCOL_ERR)
    );

    always #5 PCLK = ~PCLK;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mem_m [1024];
    int          wr_m;
    int          rd_m;
    logic        perr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_status(input string tag);
        @(negedge PCLK);
        chk({tag, " wr_count"}, {16'd0, WR_COUNT}, wr_m);
        chk({tag, " rd_count"}, {16'd0, RD_COUNT}, rd_m);
        chk({tag, " protocol_err"}, {31'd0, PROTOCOL_ERR}, {31'd0, perr_m});
        align();
    endtask

    task automatic reset_dut();
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        align();
        align();
        PRESET = 1'b0;
        wr_m   = 0;
        rd_m   = 0;
        perr_m = 1'b0;
    endtask

    // Full transfer; entered and left one time unit after a rising edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] ws, input logic inj, input string tag);
        logic        err;
        int unsigned idx;
        logic [31:0] exp_rd;
        int          waits;
        logic        done;
        err    = inj || (addr[1:0] != 2'b00);
        idx    = 32'(addr[11:2]);
        exp_rd = (wr || err) ? 32'd0 : mem_m[idx];
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        WAITSTATES = ws; ERR_INJECT = inj;
        align();
        PENABLE    = 1'b1;
        WAITSTATES = 4'($urandom);
        ERR_INJECT = 1'($urandom);
        waits = 0;
        done  = 1'b0;
        while (!done && waits < 40) begin
            @(negedge PCLK);
            if (PREADY) begin
                chk({tag, " prdata"}, PRDATA, exp_rd);
                chk({tag, " pslverr"}, {31'd0, PSLVERR}, {31'd0, err});
                done = 1'b1;
            end else begin
                waits++;
            end
            align();
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        chk({tag, " wait_cycles"}, waits, {28'd0, ws});
        if (done && !err) begin
            if (wr) begin
                mem_m[idx] = data;
                if (wr_m < 65535) wr_m++;
            end else if (rd_m < 65535) begin
                rd_m++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rw;
        logic [31:0] ra;
        foreach (mem_m[i]) mem_m[i] = 32'd0;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; WAITSTATES = '0; ERR_INJECT = 1'b0;
        wr_m = 0; rd_m = 0; perr_m = 1'b0;

        // Reset values
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst prdata", PRDATA, 32'd0);
        chk("rst pready", {31'd0, PREADY}, 32'd0);
        chk("rst pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst wr_count", {16'd0, WR_COUNT}, 32'd0);
        chk("rst rd_count", {16'd0, RD_COUNT}, 32'd0);
        chk("rst protocol_err", {31'd0, PROTOCOL_ERR}, 32'd0);
        align();
        PRESET = 1'b0;

        // Basic write then read, zero wait states
        xfer(1'b1, 32'h010, 32'hDEADBEEF, 4'd0, 1'b0, "t1 wr");
        xfer(1'b0, 32'h010, 32'h0, 4'd0, 1'b0, "t1 rd");
        check_status("t1");

        // Three wait states on a read
        xfer(1'b1, 32'h020, 32'h12345678, 4'd0, 1'b0, "t2 wr");
        xfer(1'b0, 32'h020, 32'h0, 4'd3, 1'b0, "t2 rd");
        check_status("t2");

        // Misaligned and injected errors
        reset_dut();
        xfer(1'b1, 32'h006, 32'h55555555, 4'd1, 1'b0, "t3 misaligned");
        xfer(1'b1, 32'h030, 32'h77777777, 4'd0, 1'b1, "t3 inject");
        xfer(1'b0, 32'h030, 32'h0, 4'd0, 1'b0, "t3 rd");
        check_status("t3");

        // PSEL+PENABLE with no setup phase
        PSEL = 1'b1; PENABLE = 1'b1;
        align();
        PSEL = 1'b0; PENABLE = 1'b0;
        perr_m = 1'b1;
        check_status("t4 idle violation");

        // Master drops PSEL mid-access
        reset_dut();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h040; PWDATA = 32'hAAAA5555;
        WAITSTATES = 4'd5; ERR_INJECT = 1'b0;
        align();
        PENABLE = 1'b1;
        align();
        align();
        PSEL = 1'b0;
        align();
        @(negedge PCLK);
        chk("t5 drop protocol_err", {31'd0, PROTOCOL_ERR}, 32'd1);
        chk("t5 drop pready", {31'd0, PREADY}, 32'd0);
        perr_m = 1'b1;
        align();
        PENABLE = 1'b0;
        xfer(1'b0, 32'h040, 32'h0, 4'd0, 1'b0, "t5 rd");
        check_status("t5");

        // Reset during the second wait cycle
        reset_dut();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h050; PWDATA = 32'h11111111;
        WAITSTATES = 4'd4; ERR_INJECT = 1'b0;
        align();
        PENABLE = 1'b1;
        align();
        PRESET = 1'b1;
        align();
        @(negedge PCLK);
        chk("t6 pready", {31'd0, PREADY}, 32'd0);
        chk("t6 wr_count", {16'd0, WR_COUNT}, 32'd0);
        chk("t6 rd_count", {16'd0, RD_COUNT}, 32'd0);
        align();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        wr_m = 0; rd_m = 0; perr_m = 1'b0;
        xfer(1'b0, 32'h050, 32'h0, 4'd2, 1'b0, "t6 rd");

        // Address aliasing above the decoded range
        xfer(1'b1, 32'h1004, 32'hCAFEF00D, 4'd1, 1'b0, "t7 wr");
        xfer(1'b0, 32'h0004, 32'h0, 4'd0, 1'b0, "t7 rd");
        check_status("t7");

        // Randomized back-to-back traffic
        for (int i = 0; i < 80; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 3));
            xfer(rw, ra, $urandom, 4'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, "rand");
            if (i % 8 == 7) check_status("rand");
        end
        check_status("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
